mips_muldiv_seq: RTL and testbench
==================================

// Module: mips_muldiv_seq
// PURPOSE
//  Multi-cycle sequencer owning the HI/LO register pair for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Replaces single-cycle '*', '/' and '%' with an iterative 1-bit/cycle shift-add multiplier and restoring divider.
//  Sits beside the main ALU. Exposes busy, and stalls the pipeline on MFHI/MFLO while an op is in flight.
// PARAMETERS
//  XLEN  32  operand width; HI and LO are each XLEN bits; iteration count = XLEN
// PORTS
//  clk       in   1     clock, all state on posedge
//  rst_n     in   1     asynchronous, active-low reset
//  start     in   1     request; accepted only when ready=1
//  op        in   3     muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO
//  src_a     in   XLEN  multiplicand / dividend / MTHI/MTLO data
//  src_b     in   XLEN  multiplier / divisor
//  flush     in   1     cancel in-flight op; HI/LO keep their old values
//  mf_req    in   1     decode stage holds MFHI/MFLO
//  ready     out  1     = (state==IDLE)
//  busy      out  1     = !ready
//  stall     out  1     = mf_req & busy (combinational)
//  done      out  1     1-cycle pulse when HI/LO are updated by MUL/DIV
//  hi, lo    out  XLEN  architectural HI/LO registers
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, hi=lo=0, done=0, counter=0, internal regs=0. Applies mid-operation too.
//  FSM: IDLE -> PREP -> ITER (XLEN cycles) -> FIX -> IDLE.
//   IDLE: start with MTHI/MTLO writes hi/lo <= src_a at the next edge; stays in IDLE; no done pulse.
//   IDLE: start with MUL/DIV latches op and operands, and goes to PREP.
//   PREP (1 cycle): compute magnitudes for signed ops and record sign bits; cnt <= 0.
//   ITER: one shift-add or restoring step per cycle; cnt increments; on cnt==XLEN-1 go to FIX.
//   FIX (1 cycle): apply signs, write hi/lo, assert done in the cycle after the write, return to IDLE.
//  Latency: the start edge to the hi/lo update edge is XLEN+2 edges (34 for XLEN=32). A new start is accepted in the done cycle.
//  start while busy: ignored, with no side effects; the requester must hold start until ready.
//  flush: state <= IDLE at the next edge, hi/lo unchanged, no done. flush has priority over a FIX write in the same cycle.
//  MULT/MULTU: {hi,lo} = full 2*XLEN product. Signed product is negated iff sign(a)^sign(b).
//  DIV/DIVU: lo = quotient, hi = remainder.
//   Signed quotient sign = sign(a)^sign(b); remainder takes the sign of the dividend (truncating division).
//   0x80000000 / -1 (signed): lo=0x80000000, hi=0 (no trap).
//  Magnitudes are computed as XLEN-bit unsigned values; the abs of the most negative value is its own bit pattern.
// CONFIGURATION
//  MULDIV_DIVZERO_TRAP_EN defined:
//   - adds output div_zero (1 bit), which pulses together with done when a DIV/DIVU divisor is 0.
//   - hi/lo are left unchanged; the op still takes the full latency.
//  MULDIV_DIVZERO_TRAP_EN undefined:
//   - no div_zero port; the algorithm runs to completion.
//   - DIVU x/0 gives lo=all-ones, hi=x.
//   - DIV x/0 gives the magnitude result with the sign fix applied.
// STRUCTURE
//  Package mips_muldiv_pkg holds:
//   - muldiv_op_t enum: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5
//   - muldiv_state_t enum: IDLE, PREP, ITER, FIX
//   - localparam for the counter width, $clog2(XLEN)
//  Sub-module mips_muldiv_iter: combinational single step (shift-add or restore-subtract) on {acc, q}.
//   The FSM, counter, sign handling and hi/lo registers stay in mips_muldiv_seq.
// TESTING
//  T1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at start+35 cycles, hi=0xFFFFFFFE, lo=0x00000001
//  T2 MULT a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF
//  T3 DIV a=0x80000000 b=-1 -> lo=0x80000000 hi=0; DIVU a=5 b=0 -> lo=0xFFFFFFFF hi=5 (macro off), div_zero=1 with hi/lo unchanged (macro on)
//  T4 MTHI 0x1234 then MTLO 0x5678 on back-to-back cycles -> hi=0x1234 lo=0x5678, ready stays 1, done never set
//  T5 mf_req=1 during DIVU -> stall=1 every busy cycle and drops in the done cycle; start pulsed while busy -> ignored, result matches the first op
//  T6 rst_n low at ITER cnt=10 -> hi=lo=0, ready=1 immediately; flush at cnt=5 -> hi/lo keep prior values, no done pulse

Source files
------------

// File: rtl/mips_muldiv_pkg.sv
// rtl/mips_muldiv_pkg.sv - shared types and sizing for the HI/LO multiply/divide sequencer
package mips_muldiv_pkg;

    localparam int MULDIV_XLEN  = 32;
    localparam int MULDIV_CNT_W = $clog2(MULDIV_XLEN);

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } muldiv_state_t;

endpackage

// File: rtl/mips_muldiv_seq_if.sv
// rtl/mips_muldiv_seq_if.sv - request/result bundle between pipeline and muldiv sequencer (MULDIV_DIVZERO_TRAP_EN adds div_zero)
interface mips_muldiv_seq_if
    import mips_muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) ();

    logic            start;
    muldiv_op_t      op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            mf_req;
    logic            ready;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
`ifdef MULDIV_DIVZERO_TRAP_EN
    logic            div_zero;

    modport master (
        output start, op, src_a, src_b, flush, mf_req,
        input  ready, busy, stall, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, src_a, src_b, flush, mf_req,
        output ready, busy, stall, done, hi, lo, div_zero
    );
`else
    modport master (
        output start, op, src_a, src_b, flush, mf_req,
        input  ready, busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush, mf_req,
        output ready, busy, stall, done, hi, lo
    );
`endif

endinterface

// File: rtl/mips_muldiv_iter.sv
// rtl/mips_muldiv_iter.sv - one combinational shift-add (multiply) or restoring (divide) step on {acc, q}
module mips_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            is_div_i,
    input  logic [XLEN-1:0] m_i,
    input  logic [XLEN-1:0] acc_i,
    input  logic [XLEN-1:0] q_i,
    output logic [XLEN-1:0] acc_o,
    output logic [XLEN-1:0] q_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;

    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        acc_o   = acc_i;
        q_o     = q_i;
        if (!is_div_i) begin
            // Multiplier bits retire from q's LSB while product bits enter at its MSB.
            sum   = {1'b0, acc_i} + (q_i[0] ? {1'b0, m_i} : '0);
            acc_o = sum[XLEN:1];
            q_o   = {sum[0], q_i[XLEN-1:1]};
        end else begin
            // Partial remainder is always below the divisor, so the difference fits in XLEN bits.
            shifted = {acc_i, q_i[XLEN-1]};
            diff    = shifted[XLEN-1:0] - m_i;
            if (shifted >= {1'b0, m_i}) begin
                acc_o = diff;
                q_o   = {q_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = shifted[XLEN-1:0];
                q_o   = {q_i[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mips_muldiv_seq.sv
// rtl/mips_muldiv_seq.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; MULDIV_DIVZERO_TRAP_EN enables div_zero trap
module mips_muldiv_seq
    import mips_muldiv_pkg::*;
#(
    parameter int XLEN = MULDIV_XLEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mips_muldiv_seq_if.slave        bus
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    muldiv_state_t     state_q;
    muldiv_op_t        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   m_q;
    logic [XLEN-1:0]   acc_q;
    logic [XLEN-1:0]   q_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q_q;
    logic              neg_r_q;
    logic              done_q;

    logic [XLEN-1:0]   acc_d;
    logic [XLEN-1:0]   q_d;
    logic              is_div;
    logic              signed_op;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic              div_blocked;

    assign is_div    = (op_q == DIV) || (op_q == DIVU);
    assign signed_op = (op_q == MULT) || (op_q == DIV);
    assign sign_a    = signed_op & a_q[XLEN-1];
    assign sign_b    = signed_op & b_q[XLEN-1];
    // The most negative value negates to itself, which is exactly its magnitude as unsigned.
    assign mag_a     = sign_a ? -a_q : a_q;
    assign mag_b     = sign_b ? -b_q : b_q;

    assign prod_mag  = {acc_q, q_q};
    assign prod_fix  = neg_q_q ? -prod_mag : prod_mag;
    assign quot_fix  = neg_q_q ? -q_q : q_q;
    assign rem_fix   = neg_r_q ? -acc_q : acc_q;

`ifdef MULDIV_DIVZERO_TRAP_EN
    logic dz_q;
    logic div_zero_q;

    assign div_blocked  = dz_q;
    assign bus.div_zero = div_zero_q;
`else
    assign div_blocked  = 1'b0;
`endif

    mips_muldiv_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .is_div_i (is_div),
        .m_i      (m_q),
        .acc_i    (acc_q),
        .q_i      (q_q),
        .acc_o    (acc_d),
        .q_o      (q_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= MULT;
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            acc_q      <= '0;
            q_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            div_zero_q <= 1'b0;
`endif
            if (bus.flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            case (bus.op)
                                MTHI: hi_q <= bus.src_a;
                                MTLO: lo_q <= bus.src_a;
                                MULT, MULTU, DIV, DIVU: begin
                                    op_q    <= bus.op;
                                    a_q     <= bus.src_a;
                                    b_q     <= bus.src_b;
                                    state_q <= PREP;
                                end
                                default: ;
                            endcase
                        end
                    end
                    PREP: begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        neg_q_q <= sign_a ^ sign_b;
                        neg_r_q <= sign_a;
                        if (is_div) begin
                            m_q <= mag_b;
                            q_q <= mag_a;
                        end else begin
                            m_q <= mag_a;
                            q_q <= mag_b;
                        end
`ifdef MULDIV_DIVZERO_TRAP_EN
                        dz_q    <= is_div && (b_q == '0);
`endif
                        state_q <= ITER;
                    end
                    ITER: begin
                        acc_q <= acc_d;
                        q_q   <= q_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= FIX;
                        end
                    end
                    FIX: begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        if (!is_div) begin
                            {hi_q, lo_q} <= prod_fix;
                        end else if (!div_blocked) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
`ifdef MULDIV_DIVZERO_TRAP_EN
                        div_zero_q <= is_div && dz_q;
`endif
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.busy  = (state_q != IDLE);
    assign bus.stall = bus.mf_req & (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// tb/tb_mips_muldiv_seq.sv - randomized and directed bench for mips_muldiv_seq against an arithmetic HI/LO model
module tb_mips_muldiv_seq;
    import mips_muldiv_pkg::*;

    logic clk;
    logic rst_n;

    mips_muldiv_seq_if #(.XLEN(32)) bus ();

    mips_muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dz = 1'b0;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          zdiv;
    } row_t;

    task automatic model_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          sa;
        int          sb;
        logic [31:0] ones;
        logic [31:0] mag;
        sa   = $signed(a);
        sb   = $signed(b);
        ones = '1;
        m_dz = 1'b0;
        case (op)
            MULT: begin
                sp   = longint'($signed(a)) * longint'($signed(b));
                m_hi = sp[63:32];
                m_lo = sp[31:0];
            end
            MULTU: begin
                up   = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32];
                m_lo = up[31:0];
            end
            DIVU: begin
                if (b == 0) begin
`ifdef MULDIV_DIVZERO_TRAP_EN
                    m_dz = 1'b1;
`else
                    m_lo = ones;
                    m_hi = a;
`endif
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            DIV: begin
                if (b == 0) begin
`ifdef MULDIV_DIVZERO_TRAP_EN
                    m_dz = 1'b1;
`else
                    mag  = a[31] ? -a : a;
                    m_lo = a[31] ? -ones : ones;
                    m_hi = a[31] ? -mag : mag;
`endif
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'h0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            MTHI: m_hi = a;
            MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Caller is just past a negedge; returns at the negedge where done is seen (lat counts negedges).
    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic dz);
        lat = -1;
        dz  = 1'b0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = i;
`ifdef MULDIV_DIVZERO_TRAP_EN
                dz = bus.div_zero;
`endif
                break;
            end
        end
    endtask

    task automatic do_mt(input muldiv_op_t op, input logic [31:0] val);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = val;
        @(negedge clk);
        bus.start = 1'b0;
        model_op(op, val, 32'h0);
    endtask

    task automatic test_reset();
        total_cnt++;
        if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0) begin
            $display("FAIL reset_flags: ready=%b busy=%b done=%b stall=%b, required 1 0 0 0",
                     bus.ready, bus.busy, bus.done, bus.stall);
        end else pass_cnt++;
        total_cnt++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            $display("FAIL reset_hilo: hi=%h lo=%h, required 0 0", bus.hi, bus.lo);
        end else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.ready !== 1'b1 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            $display("FAIL reset_release: ready=%b hi=%h lo=%h, required 1 0 0", bus.ready, bus.hi, bus.lo);
        end else pass_cnt++;
    endtask

    task automatic test_directed();
        row_t        rows[8];
        int          lat;
        logic        dz;
        logic [31:0] eh;
        logic [31:0] el;
        rows[0] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        rows[1] = '{MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        rows[2] = '{DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        rows[3] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        rows[4] = '{DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        rows[5] = '{DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'h0000_0001, 1'b1};
        rows[6] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        rows[7] = '{DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        for (int r = 0; r < 8; r++) begin
            model_op(rows[r].op, rows[r].a, rows[r].b);
            eh = rows[r].hi;
            el = rows[r].lo;
`ifdef MULDIV_DIVZERO_TRAP_EN
            if (rows[r].zdiv) begin
                eh = m_hi;
                el = m_lo;
            end
`endif
            run_op(rows[r].op, rows[r].a, rows[r].b, lat, dz);
            total_cnt++;
            if (lat !== 35) $display("FAIL directed_latency[%0d]: %0d, required 35", r, lat);
            else pass_cnt++;
            total_cnt++;
            if (bus.hi !== eh || bus.lo !== el)
                $display("FAIL directed_result[%0d]: hi=%h lo=%h, required hi=%h lo=%h", r, bus.hi, bus.lo, eh, el);
            else pass_cnt++;
`ifdef MULDIV_DIVZERO_TRAP_EN
            total_cnt++;
            if (dz !== rows[r].zdiv) $display("FAIL directed_div_zero[%0d]: %b, required %b", r, dz, rows[r].zdiv);
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_mt();
        logic saw_done;
        saw_done = 1'b0;
        bus.start = 1'b1;
        bus.op    = MTHI;
        bus.src_a = 32'h0000_1234;
        @(negedge clk);
        saw_done |= bus.done;
        total_cnt++;
        if (bus.ready !== 1'b1 || bus.hi !== 32'h0000_1234)
            $display("FAIL mthi: ready=%b hi=%h, required 1 00001234", bus.ready, bus.hi);
        else pass_cnt++;
        bus.op    = MTLO;
        bus.src_a = 32'h0000_5678;
        @(negedge clk);
        bus.start = 1'b0;
        saw_done |= bus.done;
        total_cnt++;
        if (bus.ready !== 1'b1 || bus.hi !== 32'h0000_1234 || bus.lo !== 32'h0000_5678)
            $display("FAIL mtlo: ready=%b hi=%h lo=%h, required 1 00001234 00005678", bus.ready, bus.hi, bus.lo);
        else pass_cnt++;
        model_op(MTHI, 32'h0000_1234, 32'h0);
        model_op(MTLO, 32'h0000_5678, 32'h0);
        @(negedge clk);
        saw_done |= bus.done;
        total_cnt++;
        if (saw_done !== 1'b0) $display("FAIL mt_no_done: saw done=%b, required 0", saw_done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic        dz;
        for (int n = 0; n < 30; n++) begin
            op = muldiv_op_t'(3'($urandom_range(0, 3)));
            a  = pick();
            b  = pick();
            model_op(op, a, b);
            run_op(op, a, b, lat, dz);
            total_cnt++;
            if (lat !== 35 || bus.ready !== 1'b1)
                $display("FAIL rand_timing[%0d]: lat=%0d ready=%b, required 35 1", n, lat, bus.ready);
            else pass_cnt++;
            total_cnt++;
            if (bus.hi !== m_hi || bus.lo !== m_lo)
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: hi=%h lo=%h, required hi=%h lo=%h",
                         n, op, a, b, bus.hi, bus.lo, m_hi, m_lo);
            else pass_cnt++;
`ifdef MULDIV_DIVZERO_TRAP_EN
            total_cnt++;
            if (dz !== m_dz) $display("FAIL rand_div_zero[%0d]: %b, required %b", n, dz, m_dz);
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        a = $urandom;
        b = 32'($urandom_range(1, 1000));
        model_op(DIVU, a, b);
        lat = -1;
        bus.mf_req = 1'b1;
        bus.start  = 1'b1;
        bus.op     = DIVU;
        bus.src_a  = a;
        bus.src_b  = b;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (i == 5) begin
                bus.start = 1'b1;
                bus.op    = MULTU;
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
            if (i == 6) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
            total_cnt++;
            if (bus.stall !== 1'b1 || bus.busy !== 1'b1)
                $display("FAIL stall_busy[%0d]: stall=%b busy=%b, required 1 1", i, bus.stall, bus.busy);
            else pass_cnt++;
        end
        total_cnt++;
        if (lat !== 35 || bus.stall !== 1'b0)
            $display("FAIL stall_done: lat=%0d stall=%b, required 35 0", lat, bus.stall);
        else pass_cnt++;
        total_cnt++;
        if (bus.hi !== m_hi || bus.lo !== m_lo)
            $display("FAIL ignored_start_result: hi=%h lo=%h, required hi=%h lo=%h", bus.hi, bus.lo, m_hi, m_lo);
        else pass_cnt++;
        bus.mf_req = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL ignored_start_idle: ready=%b done=%b, required 1 0", bus.ready, bus.done);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        do_mt(MTHI, 32'hA5A5_0001);
        do_mt(MTLO, 32'h5A5A_0002);
        bus.start = 1'b1;
        bus.op    = MULTU;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL reset_mid_pre: busy=%b, required 1", bus.busy);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.ready !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL reset_mid: hi=%h lo=%h ready=%b done=%b, required 0 0 1 0",
                     bus.hi, bus.lo, bus.ready, bus.done);
        else pass_cnt++;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.ready !== 1'b1 || bus.hi !== 32'h0)
            $display("FAIL reset_mid_after: ready=%b hi=%h, required 1 0", bus.ready, bus.hi);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        logic saw_done;
        do_mt(MTHI, 32'hCAFE_0011);
        do_mt(MTLO, 32'hBEEF_0022);
        bus.start = 1'b1;
        bus.op    = DIV;
        bus.src_a = $urandom;
        bus.src_b = 32'($urandom_range(1, 50));
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        total_cnt++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL flush_iter: ready=%b done=%b, required 1 0", bus.ready, bus.done);
        else pass_cnt++;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_done |= bus.done;
        end
        total_cnt++;
        if (saw_done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo)
            $display("FAIL flush_iter_hold: done_seen=%b hi=%h lo=%h, required 0 %h %h",
                     saw_done, bus.hi, bus.lo, m_hi, m_lo);
        else pass_cnt++;
        bus.start = 1'b1;
        bus.op    = MULT;
        bus.src_a = 32'h1234_5678;
        bus.src_b = 32'h0000_0003;
        for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
        end
        total_cnt++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0)
            $display("FAIL flush_fix_pre: busy=%b done=%b, required 1 0", bus.busy, bus.done);
        else pass_cnt++;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        total_cnt++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.hi !== m_hi || bus.lo !== m_lo)
            $display("FAIL flush_fix: done=%b ready=%b hi=%h lo=%h, required 0 1 %h %h",
                     bus.done, bus.ready, bus.hi, bus.lo, m_hi, m_lo);
        else pass_cnt++;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = MULT;
        bus.src_a  = '0;
        bus.src_b  = '0;
        bus.flush  = 1'b0;
        bus.mf_req = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_directed();
        test_mt();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
